// File: rtl/uart_frame_loader.sv
// Frame parser behind uart_rx: SYNC, CMD, LEN_HI, LEN_LO, payload, XOR checksum.
// Streams payload into the weight/image buffers and issues the accelerator start pulse.
module uart_frame_loader #(
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned TIMEOUT_CYCLES = 500000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   input  logic              accel_busy,
   output logic              mem_we,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              accel_start,
   output logic              frame_ok,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CSUM
   } state_t;

   typedef enum logic [1:0] {
      CMD_LOAD_W = 2'd0, CMD_LOAD_IMG = 2'd1, CMD_START = 2'd2, CMD_BAD = 2'd3
   } cmd_t;

   state_t              state, state_d;
   cmd_t                cmd, cmd_d;
   logic [15:0]         len, len_d;
   logic [7:0]          csum, csum_d;
   logic [ADDR_W-1:0]   addr, addr_d;
   logic [TIMER_W-1:0]  timer, timer_d;
   logic                timeout;

   logic                mem_we_d, mem_sel_d, accel_start_d, frame_ok_d, frame_err_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [7:0]          mem_wdata_d;

   // Timeout fires on the edge that would make the inter-byte gap TIMEOUT_CYCLES long.
   assign timeout = (state != S_IDLE) && (timer == TIMER_LAST);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d       = state;
      cmd_d         = cmd;
      len_d         = len;
      csum_d        = csum;
      addr_d        = addr;
      timer_d       = (state == S_IDLE) ? '0 : timer + TIMER_W'(1);
      mem_we_d      = 1'b0;
      mem_sel_d     = mem_sel;
      mem_addr_d    = mem_addr;
      mem_wdata_d   = mem_wdata;
      accel_start_d = 1'b0;
      frame_ok_d    = 1'b0;
      frame_err_d   = 1'b0;

      if (timeout) begin
         frame_err_d = 1'b1;
         state_d     = S_IDLE;
         timer_d     = '0;
      end else if (rx_done) begin
         timer_d = '0;
         case (state)
            S_IDLE: begin
               if (rx_data == SYNC_BYTE) begin
                  state_d = S_CMD;
                  addr_d  = '0;
               end
            end
            S_CMD: begin
               if (rx_data[1:0] == CMD_BAD) begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  cmd_d   = cmd_t'(rx_data[1:0]);
                  csum_d  = rx_data;
                  state_d = S_LEN_H;
               end
            end
            S_LEN_H: begin
               len_d   = {rx_data, len[7:0]};
               csum_d  = csum ^ rx_data;
               state_d = S_LEN_L;
            end
            S_LEN_L: begin
               len_d   = {len[15:8], rx_data};
               csum_d  = csum ^ rx_data;
               // START payload is still consumed so the checksum byte lines up.
               state_d = (len_d != 16'd0) ? S_PAYLOAD : S_CSUM;
            end
            S_PAYLOAD: begin
               csum_d = csum ^ rx_data;
               len_d  = len - 16'd1;
               if (cmd != CMD_START) begin
                  mem_we_d    = 1'b1;
                  mem_sel_d   = cmd[0];
                  mem_addr_d  = addr;
                  mem_wdata_d = rx_data;
                  addr_d      = addr + ADDR_W'(1);
               end
               if (len == 16'd1) state_d = S_CSUM;
            end
            S_CSUM: begin
               state_d = S_IDLE;
               if (rx_data != csum) begin
                  frame_err_d = 1'b1;
               end else if (cmd == CMD_START) begin
                  if (accel_busy) begin
                     frame_err_d = 1'b1;
                  end else begin
                     frame_ok_d    = 1'b1;
                     accel_start_d = 1'b1;
                  end
               end else begin
                  frame_ok_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cmd         <= CMD_LOAD_W;
         len         <= '0;
         csum        <= '0;
         addr        <= '0;
         timer       <= '0;
         mem_we      <= 1'b0;
         mem_sel     <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         accel_start <= 1'b0;
         frame_ok    <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         cmd         <= cmd_d;
         len         <= len_d;
         csum        <= csum_d;
         addr        <= addr_d;
         timer       <= timer_d;
         mem_we      <= mem_we_d;
         mem_sel     <= mem_sel_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         accel_start <= accel_start_d;
         frame_ok    <= frame_ok_d;
         frame_err   <= frame_err_d;
         busy        <= (state_d != S_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: byte-per-vector table plus hand sequences
// for timeout, mid-frame reset and address wrap (ADDR_W=2, TIMEOUT_CYCLES=100).
module tb_uart_frame_loader;

   localparam int ADDR_W  = 2;
   localparam int TIMEOUT = 100;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        rx_data;
   logic              rx_done;
   logic              accel_busy;
   logic              mem_we;
   logic              mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              accel_start;
   logic              frame_ok;
   logic              frame_err;
   logic              busy;

   int checks = 0;
   int errors = 0;

   uart_frame_loader #(
      .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT), .SYNC_BYTE(8'hA5)
   ) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .accel_busy(accel_busy), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .accel_start(accel_start),
      .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // One byte on the wire plus the outputs expected one cycle after rx_done.
   typedef struct {
      logic [7:0]        data;
      logic              abusy;
      logic              we;
      logic              sel;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        wdata;
      logic              ok;
      logic              err;
      logic              start;
      logic              bsy;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive on the falling edge; the outputs of the consuming edge are visible on return.
   task automatic send_byte(input logic [7:0] b, input logic ab);
      @(negedge clk);
      rx_data    = b;
      rx_done    = 1'b1;
      accel_busy = ab;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = ~b;
   endtask

   task automatic apply(input vec_t v, input string name);
      send_byte(v.data, v.abusy);
      check({name, " pulses"}, {27'd0, mem_we, frame_ok, frame_err, accel_start, busy},
            {27'd0, v.we, v.ok, v.err, v.start, v.bsy});
      if (v.we)
         check({name, " write"}, {21'd0, mem_sel, mem_addr, mem_wdata},
               {21'd0, v.sel, v.addr, v.wdata});
   endtask

   // Plain byte: no write, no pulse, just a busy expectation.
   function automatic vec_t b(input logic [7:0] d, input logic bsy);
      return '{d, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, bsy};
   endfunction

   function automatic vec_t w(input logic [7:0] d, input logic sel, input logic [ADDR_W-1:0] a);
      return '{d, 1'b0, 1'b1, sel, a, d, 1'b0, 1'b0, 1'b0, 1'b1};
   endfunction

   function automatic vec_t fin(input logic [7:0] d, input logic ab, input logic ok,
                                input logic err, input logic st);
      return '{d, ab, 1'b0, 1'b0, '0, 8'h00, ok, err, st, 1'b0};
   endfunction

   initial begin
      int n;
      reset      = 1'b1;
      rx_data    = 8'h00;
      rx_done    = 1'b0;
      accel_busy = 1'b0;

      // LOAD_W len 3: checksum 00^00^03^11^22^33 = 03
      tbl.push_back(b(8'hA5, 1)); tbl.push_back(b(8'h00, 1));
      tbl.push_back(b(8'h00, 1)); tbl.push_back(b(8'h03, 1));
      tbl.push_back(w(8'h11, 0, 2'd0)); tbl.push_back(w(8'h22, 0, 2'd1));
      tbl.push_back(w(8'h33, 0, 2'd2));
      tbl.push_back(fin(8'h03, 0, 1, 0, 0));
      // LOAD_IMG len 2 with wrong checksum (correct is 01^00^02^AA^BB = 12)
      tbl.push_back(b(8'hA5, 1)); tbl.push_back(b(8'h01, 1));
      tbl.push_back(b(8'h00, 1)); tbl.push_back(b(8'h02, 1));
      tbl.push_back(w(8'hAA, 1, 2'd0)); tbl.push_back(w(8'hBB, 1, 2'd1));
      tbl.push_back(fin(8'h13, 0, 0, 1, 0));
      // START, accelerator idle
      tbl.push_back(b(8'hA5, 1)); tbl.push_back(b(8'h02, 1));
      tbl.push_back(b(8'h00, 1)); tbl.push_back(b(8'h00, 1));
      tbl.push_back(fin(8'h02, 0, 1, 0, 1));
      // START, accelerator busy
      tbl.push_back(b(8'hA5, 1)); tbl.push_back(b(8'h02, 1));
      tbl.push_back(b(8'h00, 1)); tbl.push_back(b(8'h00, 1));
      tbl.push_back(fin(8'h02, 1, 0, 1, 0));
      // Garbage dropped in IDLE, then invalid command
      tbl.push_back(b(8'h00, 0)); tbl.push_back(b(8'hFF, 0));
      tbl.push_back(b(8'hA5, 1));
      tbl.push_back(fin(8'h03, 0, 0, 1, 0));
      // LOAD_W len 5 wraps the 2-bit address: checksum 05^01^02^03^04^05 = 04
      tbl.push_back(b(8'hA5, 1)); tbl.push_back(b(8'h00, 1));
      tbl.push_back(b(8'h00, 1)); tbl.push_back(b(8'h05, 1));
      tbl.push_back(w(8'h01, 0, 2'd0)); tbl.push_back(w(8'h02, 0, 2'd1));
      tbl.push_back(w(8'h03, 0, 2'd2)); tbl.push_back(w(8'h04, 0, 2'd3));
      tbl.push_back(w(8'h05, 0, 2'd0));
      tbl.push_back(fin(8'h04, 0, 1, 0, 0));

      #12;
      check("reset outputs", {17'd0, mem_we, mem_sel, mem_addr, mem_wdata, accel_start,
            frame_ok, frame_err, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // rx_data alone must not advance the FSM
      rx_data = 8'hA5;
      repeat (3) @(negedge clk);
      check("no strobe idle", {31'd0, busy}, 32'd0);

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // Stall in PAYLOAD: frame_err must land exactly TIMEOUT edges after the last byte
      apply(b(8'hA5, 1), "to sync"); apply(b(8'h00, 1), "to cmd");
      apply(b(8'h00, 1), "to lenh"); apply(b(8'h01, 1), "to lenl");
      n = 0;
      for (int k = 1; k <= TIMEOUT + 50; k++) begin
         @(negedge clk);
         if (frame_err) begin
            n = k;
            break;
         end
      end
      check("timeout cycle", n, TIMEOUT);
      check("timeout idle", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("timeout pulse width", {31'd0, frame_err}, 32'd0);

      // Reset mid-payload discards the frame silently
      apply(b(8'hA5, 1), "rst sync"); apply(b(8'h01, 1), "rst cmd");
      apply(b(8'h00, 1), "rst lenh"); apply(b(8'h04, 1), "rst lenl");
      apply(w(8'hAA, 1, 2'd0), "rst p0"); apply(w(8'hBB, 1, 2'd1), "rst p1");
      reset = 1'b1;
      #1;
      check("mid reset outputs", {17'd0, mem_we, mem_sel, mem_addr, mem_wdata, accel_start,
            frame_ok, frame_err, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (frame_err || busy) n++;
      end
      check("post reset quiet", n, 0);

      // Next frame parses normally: LOAD_W len 1, checksum 01^77 = 76
      apply(b(8'hA5, 1), "rec sync"); apply(b(8'h00, 1), "rec cmd");
      apply(b(8'h00, 1), "rec lenh"); apply(b(8'h01, 1), "rec lenl");
      apply(w(8'h77, 0, 2'd0), "rec p0");
      apply(fin(8'h76, 0, 1, 0, 0), "rec csum");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
